// File: rtl/int8_dequantizer.sv
// Two-stage valid/ready pipelined int8 dequantizer: y = round(q * max_num / 127) via a fixed-point reciprocal.
// Optional clamping of results to OUT_WIDTH is enabled by defining DEQUANTIZER_SATURATE_EN.
module int8_dequantizer #(
    parameter int IN_WIDTH       = 8,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 1,
    parameter int MAX_NUM_WIDTH  = 16,
    parameter int OUT_WIDTH      = MAX_NUM_WIDTH + 1,
    parameter int RECIP_SHIFT    = 16,
    parameter int RECIP          = ((2 ** RECIP_SHIFT) + 63) / 127,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0]      data_in,
    input  logic [MAX_NUM_WIDTH-1:0]                        max_num_in,
    input  logic                                            data_in_valid,
    output logic                                            data_in_ready,
    output logic [OUT_WIDTH*IN_SIZE*IN_PARALLELISM-1:0]     data_out,
    output logic                                            data_out_valid,
    input  logic                                            data_out_ready,
    output logic [COUNT_WIDTH-1:0]                          beat_count
);
    localparam int N  = IN_SIZE * IN_PARALLELISM;
    localparam int PW = IN_WIDTH + MAX_NUM_WIDTH + 1;
    // Headroom so prod*RECIP plus the rounding half never overflows.
    localparam int SW = PW + RECIP_SHIFT + 2;
    localparam int YW = SW - RECIP_SHIFT;
    localparam logic signed [SW-1:0] RECIP_C = SW'(RECIP);
    localparam logic signed [SW-1:0] HALF_C  = SW'(1) << (RECIP_SHIFT - 1);

    logic                          en;
    logic                          s1_valid_reg;
    logic                          out_valid_reg;
    logic [N-1:0][PW-1:0]          prod_reg;
    logic [N-1:0][PW-1:0]          prod_next;
    logic [N-1:0][OUT_WIDTH-1:0]   data_out_reg;
    logic [N-1:0][OUT_WIDTH-1:0]   y_next;
    logic [COUNT_WIDTH-1:0]        beat_count_reg;

    assign en             = !out_valid_reg || data_out_ready;
    assign data_in_ready  = en;
    assign data_out_valid = out_valid_reg;
    assign data_out       = data_out_reg;
    assign beat_count     = beat_count_reg;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elem
            logic signed [IN_WIDTH-1:0] q;
            logic signed [PW-1:0]       q_ext;
            logic signed [PW-1:0]       m_ext;
            logic signed [PW-1:0]       p_reg_s;
            logic signed [SW-1:0]       scaled;

            assign q             = data_in[gi*IN_WIDTH +: IN_WIDTH];
            assign q_ext         = PW'(q);
            assign m_ext         = PW'({1'b0, max_num_in});
            assign prod_next[gi] = q_ext * m_ext;
            assign p_reg_s       = prod_reg[gi];
            assign scaled        = SW'(p_reg_s) * RECIP_C + HALF_C;

`ifdef DEQUANTIZER_SATURATE_EN
            logic signed [YW-1:0]      y;
            logic [OUT_WIDTH-1:0]      y_sat;
            assign y = YW'(scaled >>> RECIP_SHIFT);
            // Out of range whenever the bits above the output sign bit are not a pure sign extension.
            always_comb begin
                y_sat = y[OUT_WIDTH-1:0];
                if (y[YW-1:OUT_WIDTH-1] != {(YW-OUT_WIDTH+1){y[YW-1]}}) begin
                    y_sat = y[YW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                    : {1'b0, {(OUT_WIDTH-1){1'b1}}};
                end
            end
            assign y_next[gi] = y_sat;
`else
            assign y_next[gi] = OUT_WIDTH'(scaled >>> RECIP_SHIFT);
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            prod_reg      <= '0;
            data_out_reg  <= '0;
        end else if (en) begin
            s1_valid_reg  <= data_in_valid;
            out_valid_reg <= s1_valid_reg;
            // Bubbles advance the valid bits but leave the payload untouched.
            if (data_in_valid) begin
                prod_reg <= prod_next;
            end
            if (s1_valid_reg) begin
                data_out_reg <= y_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_reg <= '0;
        end else if (out_valid_reg && data_out_ready) begin
            beat_count_reg <= beat_count_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_int8_dequantizer.sv
// Self-checking bench for int8_dequantizer: a default-width instance and a narrow one (12-bit out, 4-bit counter).
// Expected beats are queued at accept time and compared when the pipeline model says they drain.
module tb_int8_dequantizer;
`ifdef DEQUANTIZER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = '0;
    logic [15:0] max_num_in = '0;
    logic        data_in_valid = 1'b0;
    logic        data_out_ready = 1'b0;

    logic        rdy_w, ov_w, rdy_n, ov_n;
    logic [67:0] dout_w;
    logic [47:0] dout_n;
    logic [15:0] cnt_w;
    logic [3:0]  cnt_n;

    always #5 clk = ~clk;

    int8_dequantizer dut (
        .clk(clk), .rst(rst), .data_in(data_in), .max_num_in(max_num_in),
        .data_in_valid(data_in_valid), .data_in_ready(rdy_w),
        .data_out(dout_w), .data_out_valid(ov_w),
        .data_out_ready(data_out_ready), .beat_count(cnt_w)
    );

    int8_dequantizer #(.OUT_WIDTH(12), .COUNT_WIDTH(4)) dut_n (
        .clk(clk), .rst(rst), .data_in(data_in), .max_num_in(max_num_in),
        .data_in_valid(data_in_valid), .data_in_ready(rdy_n),
        .data_out(dout_n), .data_out_valid(ov_n),
        .data_out_ready(data_out_ready), .beat_count(cnt_n)
    );

    typedef struct {
        logic [67:0] w;
        logic [47:0] n;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passes = 0;
    int accepted = 0;
    logic        model_s1 = 1'b0;
    logic        model_ov = 1'b0;
    logic [15:0] model_cnt = '0;
    logic        prev_stall = 1'b0;
    logic [67:0] prev_w = '0;
    logic [47:0] prev_n = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic longint ref_y(input int q, input int m);
        longint p;
        p = longint'(q) * longint'(m) * 516 + 64'sd32768;
        return p >>> 16;
    endfunction

    function automatic logic [63:0] reduce(input longint y, input int w);
        longint mx, mn, r;
        mx = (64'sd1 <<< (w - 1)) - 1;
        mn = -mx - 1;
        r = y;
        if (SAT && r > mx) r = mx;
        if (SAT && r < mn) r = mn;
        return r;
    endfunction

    function automatic exp_t make_exp(input logic [31:0] d, input logic [15:0] m);
        exp_t e;
        logic [7:0]  qb;
        logic [63:0] t;
        longint y;
        for (int i = 0; i < 4; i++) begin
            qb = d[i*8 +: 8];
            y = ref_y(int'($signed(qb)), int'(m));
            t = reduce(y, 17);
            e.w[i*17 +: 17] = t[16:0];
            t = reduce(y, 12);
            e.n[i*12 +: 12] = t[11:0];
        end
        return e;
    endfunction

    function automatic logic [31:0] pack_q(input int a, input int b, input int c, input int d);
        logic [31:0] v;
        v[7:0]   = 8'(a);
        v[15:8]  = 8'(b);
        v[23:16] = 8'(c);
        v[31:24] = 8'(d);
        return v;
    endfunction

    // One clock cycle: drive at the falling edge, check 1 ns later, then step the bench's pipeline model.
    task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                         input logic [15:0] m, input logic rdy);
        logic en_m;
        exp_t e;
        rst = r; data_in_valid = v; data_in = d; max_num_in = m; data_out_ready = rdy;
        #1;
        if (r) begin
            sb.delete();
            model_s1 = 1'b0; model_ov = 1'b0; model_cnt = '0; prev_stall = 1'b0;
        end else begin
            en_m = !model_ov || rdy;
            chk("out_valid", {127'b0, ov_w}, {127'b0, model_ov});
            chk("out_valid_n", {127'b0, ov_n}, {127'b0, model_ov});
            chk("in_ready", {127'b0, rdy_w}, {127'b0, en_m});
            chk("in_ready_n", {127'b0, rdy_n}, {127'b0, en_m});
            chk("beat_count", 128'(cnt_w), 128'(model_cnt));
            chk("beat_count_n", 128'(cnt_n), 128'(model_cnt[3:0]));
            if (prev_stall) begin
                chk("stall_hold", 128'(dout_w), 128'(prev_w));
                chk("stall_hold_n", 128'(dout_n), 128'(prev_n));
            end
            if (model_ov && rdy) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 128'(sb.size()), 128'd1);
                end else begin
                    e = sb.pop_front();
                    chk("data_out", 128'(dout_w), 128'(e.w));
                    chk("data_out_n", 128'(dout_n), 128'(e.n));
                end
                model_cnt = model_cnt + 16'd1;
            end
            if (v && en_m) begin
                sb.push_back(make_exp(d, m));
                accepted++;
            end
            prev_stall = model_ov && !rdy;
            prev_w = dout_w;
            prev_n = dout_n;
            if (en_m) begin
                model_ov = model_s1;
                model_s1 = v;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [67:0] basic_exp;
        logic [63:0] t;
        logic [11:0] sat_exp;
        int i;

        // Reset, then reset values.
        cycle(1'b1, 1'b0, '0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, '0, 1'b1);
        chk("rst_data_out", 128'(dout_w), 128'd0);
        chk("rst_data_out_n", 128'(dout_n), 128'd0);

        // Basic beat {127, -127, 64, 0} at scale 1000, two-cycle latency.
        cycle(1'b0, 1'b1, pack_q(127, -127, 64, 0), 16'd1000, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        basic_exp = {17'(0), 17'(504), 17'(-1000), 17'(1000)};
        chk("basic_value", 128'(dout_w), 128'(basic_exp));
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);

        // Boundaries: zero scale, q = -128 at mid and full scale.
        cycle(1'b0, 1'b1, pack_q(-128, 127, -5, 99), 16'd0, 1'b1);
        cycle(1'b0, 1'b1, pack_q(-128, -128, 1, -1), 16'd1000, 1'b1);
        cycle(1'b0, 1'b1, pack_q(-128, 127, -127, 0), 16'hFFFF, 1'b1);

        // Narrow-output overflow: 127 at scale 4000 gives 4000, which does not fit 12 bits.
        cycle(1'b0, 1'b1, pack_q(127, 127, 127, 127), 16'd4000, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        t = SAT ? 64'd2047 : 64'hFA0;
        sat_exp = t[11:0];
        chk("narrow_overflow", 128'(dout_n[11:0]), 128'(sat_exp));
        cycle(1'b0, 1'b0, '0, '0, 1'b1);

        // Streaming: 16 back-to-back beats with ready held high.
        for (int k = 0; k < 16; k++) begin
            cycle(1'b0, 1'b1, $urandom(), 16'($urandom_range(0, 65535)), 1'b1);
        end

        // Random backpressure until 200 more beats are accepted (bounded).
        accepted = 0;
        i = 0;
        while (accepted < 200 && i < 2000) begin
            cycle(1'b0, 1'($urandom_range(0, 3) != 0), $urandom(),
                  16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
            i++;
        end
        if (accepted < 200) chk("bp_accept_budget", 128'(accepted), 128'd200);

        // Fill both stages under stall, then reset mid-stream.
        cycle(1'b0, 1'b1, $urandom(), 16'd1234, 1'b1);
        cycle(1'b0, 1'b1, $urandom(), 16'd4321, 1'b1);
        cycle(1'b0, 1'b1, $urandom(), 16'd777, 1'b0);
        cycle(1'b1, 1'b1, $urandom(), 16'd555, 1'b0);
        chk("midrst_data_out", 128'(dout_w), 128'd0);
        chk("midrst_data_out_n", 128'(dout_n), 128'd0);

        // Post-reset beats must be the only ones to appear.
        cycle(1'b0, 1'b1, pack_q(10, -20, 30, -40), 16'd5000, 1'b1);
        cycle(1'b0, 1'b1, pack_q(-1, 1, 2, -2), 16'd300, 1'b1);
        i = 0;
        while ((sb.size() != 0 || model_ov || model_s1) && i < 10) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b1);
            i++;
        end
        chk("sb_drained", 128'(sb.size()), 128'd0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
